// File: rtl/matrix_scan_capture_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matrix_scan_capture_pkg                                       |
// | Purpose  : Shared types and sizes for the 8x8 matrix scan capture block. |
// |            Holds the FSM state enum, the matrix geometry and the         |
// |            per-colour row-data type.                                     |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package matrix_scan_capture_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    // HUNT waits for a row-0 capture; COLLECT tracks the expected next row.
    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // One colour plane of one matrix row; bit set means the pixel is lit.
    typedef logic [COLS-1:0] row_t;

endpackage : matrix_scan_capture_pkg
`default_nettype wire

// File: rtl/matrix_scan_capture_sync2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sync2                                                         |
// | Purpose  : Two-flop synchronizer for a bus of WIDTH independent bits.    |
// | Ports    : CLK   - capture clock                                         |
// |            rst_n - asynchronous active-low reset, clears both stages     |
// |            i_d   - asynchronous input bus                                |
// |            o_q   - synchronized output bus (two CLK cycles of latency)   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/matrix_scan_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matrix_scan_capture                                           |
// | Purpose  : Captures frames from an 8x8 RGB matrix scanner. Each row is   |
// |            sampled once after its select has been stable for SETTLE      |
// |            cycles; an in-order 0..7 sequence is committed to a display   |
// |            buffer readable through a registered read port.               |
// | Ports    : CLK, rst_n          - clock, async active-low reset           |
// |            COMM                - scanner row select                      |
// |            DATA_R/G/B          - scanner column data, 0 = lit            |
// |            rd_row              - display read address                    |
// |            rd_r/rd_g/rd_b      - display row (1 = lit), 1-cycle latency  |
// |            frame_valid         - pulse per committed frame               |
// |            frame_err           - pulse on a broken scan sequence         |
// |            frame_cnt           - committed frame count (wraps)           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module matrix_scan_capture
    import matrix_scan_capture_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [2:0]  COMM,
    input  logic [7:0]  DATA_R,
    input  logic [7:0]  DATA_G,
    input  logic [7:0]  DATA_B,
    input  logic [2:0]  rd_row,
    output logic [7:0]  rd_r,
    output logic [7:0]  rd_g,
    output logic [7:0]  rd_b,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam logic [7:0] c_SETTLE    = 8'(SETTLE);
    localparam logic [7:0] c_SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [2:0] c_LAST_ROW  = 3'(ROWS - 1);

    logic [2:0]  w_comm_s;
    logic [23:0] w_data_s;
    row_t        w_lit_r, w_lit_g, w_lit_b;
    logic [7:0]  w_stab_next;
    logic        w_capture;

    logic [2:0]  r_comm_prev;
    logic [7:0]  r_stab;
    row_t        r_shadow_r [ROWS];
    row_t        r_shadow_g [ROWS];
    row_t        r_shadow_b [ROWS];
    row_t        r_disp_r   [ROWS];
    row_t        r_disp_g   [ROWS];
    row_t        r_disp_b   [ROWS];
    state_t      r_state;
    logic [2:0]  r_exp;
    logic        r_frame_valid;
    logic        r_frame_err;
    logic [15:0] r_frame_cnt;
    row_t        r_rd_r, r_rd_g, r_rd_b;

    sync2 #(.WIDTH(3)) u_sync_comm (
        .CLK   (CLK),
        .rst_n (rst_n),
        .i_d   (COMM),
        .o_q   (w_comm_s)
    );

    sync2 #(.WIDTH(24)) u_sync_data (
        .CLK   (CLK),
        .rst_n (rst_n),
        .i_d   ({DATA_R, DATA_G, DATA_B}),
        .o_q   (w_data_s)
    );

    // Scanner drives active-low columns; store active-high.
    assign w_lit_r = ~w_data_s[23:16];
    assign w_lit_g = ~w_data_s[15:8];
    assign w_lit_b = ~w_data_s[7:0];

    always_comb begin
        w_stab_next = r_stab;
        if (w_comm_s != r_comm_prev) begin
            w_stab_next = '0;
        end else if (r_stab != c_SETTLE) begin
            w_stab_next = r_stab + 8'd1;
        end
    end

    // Capture on the edge that loads SETTLE-1 into the counter. The second
    // term keeps SETTLE=1 (where SETTLE-1 is the reset value) to one capture
    // per dwell: only the change cycle qualifies, not a counter still at 0.
    assign w_capture = (w_stab_next == c_SETTLE_M1) &&
                       ((w_comm_s != r_comm_prev) || (r_stab != c_SETTLE_M1));

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_comm_prev <= '0;
            r_stab      <= '0;
        end else begin
            r_comm_prev <= w_comm_s;
            r_stab      <= w_stab_next;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                r_shadow_r[i] <= '0;
                r_shadow_g[i] <= '0;
                r_shadow_b[i] <= '0;
            end
        end else if (w_capture) begin
            r_shadow_r[w_comm_s] <= w_lit_r;
            r_shadow_g[w_comm_s] <= w_lit_g;
            r_shadow_b[w_comm_s] <= w_lit_b;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_exp         <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= '0;
            for (int i = 0; i < ROWS; i++) begin
                r_disp_r[i] <= '0;
                r_disp_g[i] <= '0;
                r_disp_b[i] <= '0;
            end
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            if (w_capture) begin
                case (r_state)
                    HUNT: begin
                        if (w_comm_s == 3'd0) begin
                            r_state <= COLLECT;
                            r_exp   <= 3'd1;
                        end
                    end
                    COLLECT: begin
                        if (w_comm_s == r_exp) begin
                            r_exp <= r_exp + 3'd1;
                            if (r_exp == c_LAST_ROW) begin
                                // Row 7 lands in shadow on this same edge, so
                                // it is forwarded straight from the capture.
                                for (int i = 0; i < ROWS; i++) begin
                                    if (i == ROWS - 1) begin
                                        r_disp_r[i] <= w_lit_r;
                                        r_disp_g[i] <= w_lit_g;
                                        r_disp_b[i] <= w_lit_b;
                                    end else begin
                                        r_disp_r[i] <= r_shadow_r[i];
                                        r_disp_g[i] <= r_shadow_g[i];
                                        r_disp_b[i] <= r_shadow_b[i];
                                    end
                                end
                                r_frame_valid <= 1'b1;
                                r_frame_cnt   <= r_frame_cnt + 16'd1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            if (w_comm_s == 3'd0) begin
                                r_exp <= 3'd1;
                            end else begin
                                r_state <= HUNT;
                                r_exp   <= 3'd0;
                            end
                        end
                    end
                    default: begin
                        r_state <= HUNT;
                        r_exp   <= 3'd0;
                    end
                endcase
            end
        end
    end

    // Reads sample the display before any commit on the same edge.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_r <= '0;
            r_rd_g <= '0;
            r_rd_b <= '0;
        end else begin
            r_rd_r <= r_disp_r[rd_row];
            r_rd_g <= r_disp_g[rd_row];
            r_rd_b <= r_disp_b[rd_row];
        end
    end

    assign rd_r        = r_rd_r;
    assign rd_g        = r_rd_g;
    assign rd_b        = r_rd_b;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign frame_cnt   = r_frame_cnt;

endmodule : matrix_scan_capture
`default_nettype wire

// File: doc/matrix_scan_capture.md
MATRIX_SCAN_CAPTURE -- requirements
Module: matrix_scan_capture

Interface
REQ-001 SHALL have parameter SETTLE, default 4: number of consecutive CLK cycles the synchronized row select must hold before its row is captured (range 1..255).
REQ-002 SHALL have port CLK  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port COMM  input  3  row select from the 8x8 matrix scanner.
REQ-005 SHALL have ports DATA_R, DATA_G, DATA_B  input  8 each  column data from the scanner; 0 means the pixel is lit.
REQ-006 SHALL have port rd_row  input  3  row address for the frame read port.
REQ-007 SHALL have ports rd_r, rd_g, rd_b  output  8 each  committed frame row; 1 means the pixel is lit.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse when a complete frame is committed.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when the scan sequence breaks.
REQ-010 SHALL have port frame_cnt  output  16  number of committed frames, wrapping modulo 2^16.

Function
REQ-011 SHALL pass COMM and all DATA bits through two-flop synchronizers before any use; all latencies below count from the synchronized signals.
REQ-012 SHALL reset a stability counter when the synchronized COMM differs from its previous-cycle value, and otherwise increment it, saturating at SETTLE.
REQ-013 SHALL capture a row exactly once per COMM dwell, on the cycle the counter first reaches SETTLE-1: inverted R/G/B written to shadow[COMM].
REQ-014 SHALL use FSM states HUNT and COLLECT, with a 3-bit expected-row register exp.
REQ-015 In HUNT, a capture of row 0 SHALL enter COLLECT with exp=1; captures of rows 1..7 SHALL be discarded, with no error.
REQ-016 In COLLECT, a capture with row==exp SHALL set exp=exp+1, wrapping 7->0.
REQ-017 In COLLECT, a capture of row 7 with exp==7 SHALL copy all 8 shadow rows to the display buffer in one cycle, pulse frame_valid the next cycle, increment frame_cnt, and remain in COLLECT with exp=0.
REQ-018 In COLLECT, a capture with row!=exp SHALL pulse frame_err the next cycle. If the row is 0, the FSM SHALL restart COLLECT with exp=1; otherwise it SHALL go to HUNT. The display buffer SHALL be left unchanged.
REQ-019 The read port SHALL be registered with 1-cycle latency: rd_* <= display[rd_row].
REQ-020 When a read and a commit occur in the same cycle, the read SHALL return pre-commit data; post-commit data SHALL appear from the following read.
REQ-021 frame_valid and frame_err SHALL never both be high in the same cycle.
REQ-022 A scanner that holds COMM constant SHALL produce at most one capture and no errors.

Reset
REQ-023 While rst_n is low: state=HUNT, exp=0, stability counter=0.
REQ-024 While rst_n is low: shadow and display buffers all 0 (unlit), so rd_r/rd_g/rd_b=0.
REQ-025 While rst_n is low: frame_valid=0, frame_err=0, frame_cnt=0, synchronizer flops=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; after release, the first commit SHALL require a fresh 0..7 sequence.

Structure
REQ-027 A shared package SHALL hold the FSM state enum {HUNT, COLLECT}, ROWS=8, COLS=8, and the row-data typedef (8-bit vector per colour).
REQ-028 The 2-flop synchronizer SHALL be one sub-module, sync2, instantiated for COMM and DATA; buffers and FSM stay in matrix_scan_capture.

Verification
REQ-029 Scan rows 0..7 in order, each held 10 cycles, with DATA_R=8'hFE on row 3 and all other data 8'hFF -> one frame_valid, frame_cnt=1, rd_row=3 gives rd_r=8'h01, all other rows read 0.
REQ-030 Start scanning at row 5, then continue 6,7,0..7 -> no frame_err; exactly one frame_valid, after the second row 7.
REQ-031 During COLLECT, sequence 0,1,2,4 -> frame_err pulse after row 4, FSM to HUNT, display unchanged; a following clean 0..7 -> frame_valid.
REQ-032 With SETTLE=4, hold each row only 3 cycles -> no captures, no pulses, frame_cnt stays 0.
REQ-033 Pull rst_n low during row 4 of a frame, release, then scan 5,6,7 -> no frame_valid and no frame_err; a following full 0..7 -> frame_cnt=1.
REQ-034 Read rd_row=0 on the commit cycle with new row-0 data 8'h80 -> that read returns the old value, the next read returns 8'h80.
